// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if
//   Configuration handshake bundle for prog_clk_divider.
//   The master offers a new divide value; the slave (the divider) accepts it
//   when cfg_ready is high and reports rejected values on cfg_err.
// Signals
//   cfg_div    [WIDTH]  requested divide value D
//   cfg_valid  1        cfg_div is valid
//   cfg_ready  1        divider can accept cfg_div
//   cfg_err    1        one-cycle pulse: an accepted cfg_div < 2 was rejected
interface prog_clk_divider_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;

  // Source of divide values (e.g. a control register block)
  modport master (
    output cfg_div,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_err
  );

  // The divider itself
  modport slave (
    input  cfg_div,
    input  cfg_valid,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider
//   Runtime-programmable clock divider. Divides I_CLK by any integer D >= 2,
//   high phase first: O_CLK is high for H = (D+1)/2 cycles and low for D-H.
//   A one-cycle tick marks the last input cycle of every output period.
//   A new D is loaded over the cfg handshake and only takes effect on a period
//   boundary (or on the next clock while disabled), so O_CLK never glitches.
// Optional feature
//   DIVIDER_STATUS_EN : adds parameter CNT_W and output period_cnt, a wrapping
//                       count of completed periods (increments on tick).
// Ports
//   I_CLK       in   1      input clock, rising edge
//   rst_n       in   1      asynchronous reset, active low
//   en          in   1      1 = run, 0 = hold at period start
//   cfg         slave       cfg_div / cfg_valid / cfg_ready / cfg_err
//   O_CLK       out  1      divided clock, registered
//   tick        out  1      last-cycle-of-period strobe
//   period_cnt  out  CNT_W  completed periods (DIVIDER_STATUS_EN only)
module prog_clk_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 20
`ifdef DIVIDER_STATUS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic                     I_CLK,
  input  logic                     rst_n,
  input  logic                     en,
  prog_clk_divider_if.slave        cfg,
  output logic                     O_CLK,
  output logic                     tick
`ifdef DIVIDER_STATUS_EN
  , output logic [CNT_W-1:0]       period_cnt
`endif
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] curDiv_q;
  logic [WIDTH-1:0] pendDiv_q;
  logic             pending_q;
  logic             oClk_q;
  logic             oClk_d;
  logic             cfgErr_q;
  logic [WIDTH:0]   half;
  logic             boundary;
  logic             accept;

  // High-phase length is computed one bit wider so that D = 2^WIDTH-1
  // does not wrap to zero when rounding up.
  assign half     = ({1'b0, curDiv_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign boundary = (cnt_q == curDiv_q - WIDTH'(1));
  // cfg_ready is simply "no update pending"; accept is the transfer cycle.
  assign accept   = cfg.cfg_valid & ~pending_q;

  assign cfg.cfg_ready = ~pending_q;
  assign cfg.cfg_err   = cfgErr_q;
  assign O_CLK         = oClk_q;
  assign tick          = en & boundary;

  // Next count and next output level; a wrap always restarts in the high
  // phase regardless of which D the new period uses, since H >= 1.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (!en || boundary) begin
      cnt_d = '0;
    end
    oClk_d = ({1'b0, cnt_d} < half);
  end

  // Counter, output register, pending-divide slot and error pulse.
  // Applying a pending D requires pending_q=1 while accepting requires
  // pending_q=0, so the two never collide; an accept in a boundary cycle
  // therefore waits for the following boundary.
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      curDiv_q  <= WIDTH'(DEFAULT_DIV);
      pendDiv_q <= '0;
      pending_q <= 1'b0;
      oClk_q    <= 1'b1;
      cfgErr_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      oClk_q   <= oClk_d;
      cfgErr_q <= 1'b0;
      if ((!en || boundary) && pending_q) begin
        curDiv_q  <= pendDiv_q;
        pending_q <= 1'b0;
      end
      if (accept) begin
        if (cfg.cfg_div >= WIDTH'(2)) begin
          pendDiv_q <= cfg.cfg_div;
          pending_q <= 1'b1;
        end else begin
          cfgErr_q  <= 1'b1;
        end
      end
    end
  end

`ifdef DIVIDER_STATUS_EN
  logic [CNT_W-1:0] periodCnt_q;

  // Completed-period counter; tick is already gated by en so it holds
  // while disabled.
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      periodCnt_q <= '0;
    end else if (tick) begin
      periodCnt_q <= periodCnt_q + CNT_W'(1);
    end
  end

  assign period_cnt = periodCnt_q;
`endif

endmodule
